read_returner: RTL
==================

READ_RETURNER -- requirements
Module: read_returner

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, read data width.
REQ-002 SHALL have parameter INDEX_BITS, default 7, read-tag width; DEPTH = 2**INDEX_BITS entries.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-high (port name per codebase; polarity and synchronicity fixed).
REQ-005 SHALL have port alloc_req  input  1  front end claims the next read tag this cycle.
REQ-006 SHALL have port alloc_ready  output  1  a tag is free (occupancy < DEPTH).
REQ-007 SHALL have port alloc_index  output  INDEX_BITS  tag granted when alloc_req && alloc_ready.
REQ-008 SHALL have port returner_valid  input  1  completion from burst handler, no backpressure.
REQ-009 SHALL have port returner_type  input  r_type  read or write completion.
REQ-010 SHALL have port returner_data  input  DATA_BITS  read data.
REQ-011 SHALL have port returner_index  input  INDEX_BITS  tag of completion.
REQ-012 SHALL have port rsp_valid / rsp_ready  output / input  1 / 1  in-order read response handshake.
REQ-013 SHALL have port rsp_data / rsp_index  output  DATA_BITS / INDEX_BITS  response payload.
REQ-014 SHALL have port wr_ack  output  1  one-cycle pulse per write completion.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse on read completion to a tag not PENDING.

Function
REQ-016 Each entry SHALL be in state FREE, PENDING or FILLED.
REQ-017 alloc_req && alloc_ready SHALL move entry tail to PENDING, increment tail (mod DEPTH) and occupancy; alloc_req with alloc_ready=0 SHALL be ignored.
REQ-018 alloc_index SHALL equal tail pointer combinationally.
REQ-019 Read completion to a PENDING tag SHALL store data and move it to FILLED; any other state SHALL drop data and pulse err_o next cycle.
REQ-020 Write completion SHALL pulse wr_ack the next cycle, touch no entry state, and SHALL NOT pulse err_o.
REQ-021 Responses SHALL leave strictly in tag order starting at head pointer, regardless of completion order.
REQ-022 Output register: when empty (!rsp_valid or rsp_valid&&rsp_ready) and entry head is FILLED, SHALL load rsp_data/rsp_index, set rsp_valid, free head, increment head (mod DEPTH), decrement occupancy.
REQ-023 Minimum latency: completion to head tag at cycle N SHALL give rsp_valid at N+1; a completion that fills head is loadable in the same cycle it arrives (bypass).
REQ-024 rsp_valid && !rsp_ready SHALL hold rsp_valid, rsp_data, rsp_index stable.
REQ-025 Back-to-back FILLED entries SHALL stream one per cycle while rsp_ready=1.
REQ-026 Simultaneous allocate and release SHALL leave occupancy unchanged; occupancy width INDEX_BITS+1, range 0..DEPTH.
REQ-027 Pointers SHALL wrap DEPTH-1 -> 0; full SHALL be occupancy==DEPTH, not pointer equality.
REQ-028 At occupancy==DEPTH a same-cycle release SHALL NOT enable same-cycle allocation (alloc_ready registered-state based).

Reset
REQ-029 Reset SHALL set all entries FREE, head=tail=0, occupancy=0, rsp_valid=0, rsp_data=0, rsp_index=0, wr_ack=0, err_o=0; alloc_ready=1 out of reset.
REQ-030 Reset mid-operation SHALL discard pending and held responses; inputs during reset cycle SHALL be ignored.

Structure
REQ-031 r_type, data_width and read_entries_log SHALL come from types_def; entry-state enum SHALL be added to types_def.
REQ-032 Data store SHALL be a sub-module returner_buffer (1 write, 1 async read, DEPTH x DATA_BITS); control stays in read_returner.

Verification
REQ-033 Alloc tags 0,1,2; complete reads 2(0xC),0(0xA),1(0xB), rsp_ready=1 -> responses (0,0xA),(1,0xB),(2,0xC) on consecutive cycles.
REQ-034 Fill 128 tags -> alloc_ready=0 on cycle after 128th; release tag 0 -> alloc_ready=1 next cycle, alloc_index=0.
REQ-035 rsp_ready=0 with tag 0 filled 0x1234 for 5 cycles -> rsp_valid=1, payload stable; rsp_ready=1 -> accepted once, rsp_valid drops if tag 1 not FILLED.
REQ-036 Read completion to FREE tag 5 -> err_o pulse, no response, occupancy unchanged; write completion -> wr_ack pulse only.
REQ-037 Wrap: 300 alloc/complete/release cycles -> indices 0..127,0.. in order, no err_o.
REQ-038 Assert rst_n with 3 pending, 1 held -> next cycle rsp_valid=0, alloc_index=0, alloc_ready=1.

Source files
------------

// File: rtl/types_def.sv
// Shared types for the read-return path: completion kind, widths and the
// per-tag entry state.
package types_def;
  localparam int data_width       = 16;
  localparam int read_entries_log = 7;

  typedef enum logic { R_READ = 1'b0, R_WRITE = 1'b1 } r_type;

  typedef enum logic [1:0] { E_FREE = 2'd0, E_PENDING = 2'd1, E_FILLED = 2'd2 } entry_state_t;
endpackage

// File: rtl/returner_buffer.sv
// Read-data store indexed by tag: one synchronous write port, one async read.
module returner_buffer #(
  parameter int DATA_BITS  = 16,
  parameter int INDEX_BITS = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0]  wdata,
  input  logic [INDEX_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0]  rdata
);
  localparam int DEPTH = 2**INDEX_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/read_returner.sv
// Tag allocator plus reorder store: completions arrive in any order, read
// responses leave in tag order through a single output register.
module read_returner
  import types_def::*;
#(
  parameter int DATA_BITS  = data_width,
  parameter int INDEX_BITS = read_entries_log
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic [INDEX_BITS-1:0] alloc_index,
  input  logic                  returner_valid,
  input  r_type                 returner_type,
  input  logic [DATA_BITS-1:0]  returner_data,
  input  logic [INDEX_BITS-1:0] returner_index,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_BITS-1:0]  rsp_data,
  output logic [INDEX_BITS-1:0] rsp_index,
  output logic                  wr_ack,
  output logic                  err_o
);
  localparam int DEPTH = 2**INDEX_BITS;
  localparam logic [INDEX_BITS:0] FULL = (INDEX_BITS+1)'(DEPTH);

  entry_state_t          st [DEPTH];
  logic [INDEX_BITS-1:0] head, tail;
  logic [INDEX_BITS:0]   occ;
  logic [DATA_BITS-1:0]  buf_rdata;

  logic rd_cmp, rd_ok, byp, head_filled, out_free, do_alloc, do_rel;
  logic [DATA_BITS-1:0] head_data;

  // Full is judged on occupancy from registered state only, so a release in
  // the same cycle never lets an allocation through at DEPTH.
  assign alloc_ready = (occ != FULL);
  assign alloc_index = tail;
  assign do_alloc    = alloc_req && alloc_ready;

  assign rd_cmp      = returner_valid && (returner_type == R_READ);
  assign rd_ok       = rd_cmp && (st[returner_index] == E_PENDING);
  assign byp         = rd_ok && (returner_index == head);
  assign head_filled = (st[head] == E_FILLED) || byp;
  assign head_data   = byp ? returner_data : buf_rdata;
  assign out_free    = !rsp_valid || rsp_ready;
  assign do_rel      = out_free && head_filled;

  returner_buffer #(.DATA_BITS(DATA_BITS), .INDEX_BITS(INDEX_BITS)) u_buf (
    .clk   (clk),
    .we    (rd_ok && !rst_n),
    .waddr (returner_index),
    .wdata (returner_data),
    .raddr (head),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= E_FREE;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_index <= '0;
      wr_ack    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      // Later writes win: a bypassed fill of head that is released in the
      // same cycle must end FREE.
      if (rd_ok)    st[returner_index] <= E_FILLED;
      if (do_rel)   st[head]           <= E_FREE;
      if (do_alloc) st[tail]           <= E_PENDING;

      if (do_alloc) tail <= tail + INDEX_BITS'(1);
      if (do_rel)   head <= head + INDEX_BITS'(1);
      occ <= occ + (INDEX_BITS+1)'(do_alloc) - (INDEX_BITS+1)'(do_rel);

      if (do_rel) begin
        rsp_valid <= 1'b1;
        rsp_data  <= head_data;
        rsp_index <= head;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      wr_ack <= returner_valid && (returner_type == R_WRITE);
      err_o  <= rd_cmp && !rd_ok;
    end
  end
endmodule
